// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
// Drives a WIDTH-bit up/down counter from a lower bound to an upper bound and
// back, repeating for a programmed number of sweeps, then pulses done.
// The bounds and sweep count are captured when a start is accepted, so input
// changes during a run have no effect. All outputs are registered. Each output
// register is loaded from the next-state decode, so it changes on the same
// edge as the state.

module updown_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CW-1:0]    cycles,
  output logic [WIDTH-1:0] Q,
  output logic             M,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    sweeps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};

  // Registered state and datapath
  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CW-1:0]    r_cycles;
  logic [CW-1:0]    r_sweeps;
  logic             r_m;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // Next-state values
  state_t           w_next_state;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_lo_next;
  logic [WIDTH-1:0] w_hi_next;
  logic [CW-1:0]    w_cycles_next;
  logic [CW-1:0]    w_sweeps_next;
  logic             w_err_next;
  logic             w_start_ok;
  logic [CW-1:0]    w_sweeps_inc;

  // A start is only legal with a non-empty range and a non-zero sweep count.
  // This also guarantees the counter never wraps during a run.
  assign w_start_ok   = (lo < hi) && (cycles != ZERO_C);
  assign w_sweeps_inc = r_sweeps + ONE_C;

  // Next-state, counter and bookkeeping decode
  always_comb begin
    w_next_state  = r_state;
    w_q_next      = r_q;
    w_lo_next     = r_lo;
    w_hi_next     = r_hi;
    w_cycles_next = r_cycles;
    w_sweeps_next = r_sweeps;
    w_err_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Abort wins over a simultaneous start: no run and no error.
        if (start && !abort) begin
          if (w_start_ok) begin
            w_lo_next     = lo;
            w_hi_next     = hi;
            w_cycles_next = cycles;
            w_q_next      = lo;
            w_sweeps_next = ZERO_C;
            w_next_state  = S_UP;
          end else begin
            w_err_next    = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_UP: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (r_q == r_hi) begin
          // The turnaround: hi is shown for one cycle, then count down.
          w_q_next     = r_q - ONE_W;
          w_next_state = S_DOWN;
        end else begin
          w_q_next     = r_q + ONE_W;
        end
      end
      S_DOWN: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (r_q == r_lo) begin
          w_sweeps_next = w_sweeps_inc;
          if (w_sweeps_inc == r_cycles) begin
            // Last sweep: park the counter on lo.
            w_next_state = S_DONE;
          end else begin
            w_q_next     = r_q + ONE_W;
            w_next_state = S_UP;
          end
        end else begin
          w_q_next = r_q - ONE_W;
        end
      end
      S_DONE: begin
        // DONE always falls back to IDLE; start is ignored here, and abort
        // has the same effect.
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_q_next     = ZERO_W;
      end
    endcase
  end

  // State, counter and latched run parameters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q      <= ZERO_W;
      r_lo     <= ZERO_W;
      r_hi     <= ZERO_W;
      r_cycles <= ZERO_C;
      r_sweeps <= ZERO_C;
    end else begin
      r_state  <= w_next_state;
      r_q      <= w_q_next;
      r_lo     <= w_lo_next;
      r_hi     <= w_hi_next;
      r_cycles <= w_cycles_next;
      r_sweeps <= w_sweeps_next;
    end
  end

  // Status flags registered from the next state so they align with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_m    <= (w_next_state == S_UP);
      r_busy <= (w_next_state == S_UP) || (w_next_state == S_DOWN);
      r_done <= (w_next_state == S_DONE);
      r_err  <= w_err_next;
    end
  end

  assign Q      = r_q;
  assign M      = r_m;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign sweeps = r_sweeps;

endmodule
